dma_read: RTL and testbench

AXI4 master read DMA. It fetches a contiguous word-aligned region from external memory in INCR bursts of up to 256 beats and presents the words in order on a valid/ready output stream. It is the read-side counterpart of the SA engine's write DMA and feeds input/weight buffers. A first-word-fall-through FIFO decouples R-channel timing from stream backpressure.

---
 rtl/dma_pkg.sv | 22 ++
 rtl/dma_read_fifo.sv | 60 ++++++
 rtl/dma_read.sv | 206 ++++++++++++++++++++
 tb/tb_dma_read.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared AXI constants, burst sizing and the read-DMA state encoding.
package dma_pkg;

  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [3:0] QOS_DEFAULT = 4'b1111;

  localparam int FIXED_BURST_SIZE = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN
  } rd_state_t;

endpackage

// File: rtl/dma_read_fifo.sv
// First-word-fall-through FIFO between the AXI R channel and the output stream.
// Head word is visible on dout whenever empty is low; flush empties it in one cycle.
// A push while full is accepted when a pop happens in the same cycle.
module dma_read_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  input  logic             flush
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dma_read.sv
// AXI4 read DMA: fetches a word-aligned region in INCR bursts of up to 256 beats
// and streams the words out in order through a FWFT FIFO.
// Build option: DMA_READ_ERR_ABORT_EN - an errored burst ends the job at once
// (o_error and o_done together, FIFO flushed, remaining bursts skipped).
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for i_start
//   ST_PRE   | size the next burst, or go drain when all words requested
//   ST_ADDR  | AR channel valid, fields held until ARREADY
//   ST_DATA  | accepting R beats into the FIFO until the counted last beat
//   ST_DRAIN | waiting for the consumer to empty the FIFO, then o_done
module dma_read
  import dma_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int OUT_BITS_TRANS     = 13,
  parameter int FIFO_DEPTH         = 512
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          i_start,
  input  logic [31:0]                   i_base_addr,
  input  logic [31:0]                   i_byte_len,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int OTB = OUT_BITS_TRANS;
  localparam int AW  = C_M_AXI_ADDR_WIDTH;

  rd_state_t       state;
  rd_state_t       state_next;
  logic [OTB-1:0]  num_words;
  logic [OTB-1:0]  done_words;
  logic [OTB-1:0]  remaining;
  logic [AW-1:0]   addr;
  logic [7:0]      arlen;
  logic [7:0]      beat_cnt;
  logic [8:0]      len_w;
  logic            burst_err;
  logic            beat_last;
  logic            beat_bad;
  logic            beat_fire;
  logic            burst_end;
  logic            err_set;
  logic            done_set;
  logic            fifo_flush;
  logic            fifo_full;
  logic            fifo_empty;
  logic            ar_valid;
  logic            r_ready;
  logic            done_q;
  logic            error_q;
  logic            unused_ok;

  assign len_w     = {1'b0, arlen} + 9'd1;
  assign remaining = num_words - done_words;
  // Burst end is decided by our own beat count; RLAST only feeds the error flag.
  assign beat_last = (beat_cnt == arlen);
  assign beat_bad  = (M_AXI_RRESP != RESP_OKAY) || (M_AXI_RLAST != beat_last);
  assign unused_ok = ^{M_AXI_RID, i_byte_len[31:OTB+2], i_byte_len[1:0]};

  // State register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    state_next = state;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    beat_fire  = 1'b0;
    burst_end  = 1'b0;
    err_set    = 1'b0;
    done_set   = 1'b0;
    fifo_flush = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_next = ST_PRE;
      end
      ST_PRE: begin
        if (done_words == num_words) state_next = ST_DRAIN;
        else                         state_next = ST_ADDR;
      end
      ST_ADDR: begin
        ar_valid = 1'b1;
        if (M_AXI_ARREADY) state_next = ST_DATA;
      end
      ST_DATA: begin
        r_ready   = !fifo_full;
        beat_fire = M_AXI_RVALID && !fifo_full;
        if (beat_fire && beat_last) begin
          burst_end  = 1'b1;
          err_set    = burst_err || beat_bad;
          state_next = ST_PRE;
`ifdef DMA_READ_ERR_ABORT_EN
          if (err_set) begin
            done_set   = 1'b1;
            fifo_flush = 1'b1;
            state_next = ST_IDLE;
          end
`endif
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          done_set   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Job bookkeeping: word counters, burst address/length, beat count, status pulses.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      num_words  <= '0;
      done_words <= '0;
      addr       <= '0;
      arlen      <= '0;
      beat_cnt   <= '0;
      burst_err  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q  <= done_set;
      error_q <= err_set;
      if (state == ST_IDLE && i_start) begin
        num_words  <= i_byte_len[OTB+1:2];
        addr       <= AW'(i_base_addr);
        done_words <= '0;
      end
      if (state == ST_PRE && remaining != '0) begin
        if (remaining >= OTB'(FIXED_BURST_SIZE)) arlen <= 8'hFF;
        else                                     arlen <= 8'(remaining - OTB'(1));
      end
      if (beat_fire) beat_cnt <= beat_last ? 8'd0 : beat_cnt + 8'd1;
      if (burst_end) begin
        burst_err  <= 1'b0;
        addr       <= addr + AW'({len_w, 2'b00});
        done_words <= done_words + OTB'(len_w);
      end else if (beat_fire && beat_bad) begin
        burst_err <= 1'b1;
      end
    end
  end

  dma_read_fifo #(
    .WIDTH (C_M_AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (beat_fire),
    .din   (M_AXI_RDATA),
    .pop   (o_valid && i_ready),
    .dout  (o_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .flush (fifo_flush)
  );

  assign o_valid       = !fifo_empty;
  assign o_busy        = (state != ST_IDLE);
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARLEN   = arlen;
  assign M_AXI_ARSIZE  = SIZE_4B;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = QOS_DEFAULT;
  assign M_AXI_ARVALID = ar_valid;
  assign M_AXI_RREADY  = r_ready;

endmodule

// File: tb/tb_dma_read.sv
// Self-checking bench for dma_read: randomized AXI slave and stream consumer,
// job-level reference model (expected AR list, word list, per-burst error flags).
module tb_dma_read;

  localparam int FD = 8;

  logic        aclk;
  logic        areset;
  logic        i_start;
  logic [31:0] i_base_addr;
  logic [31:0] i_byte_len;
  logic        o_busy, o_done, o_error, o_valid, i_ready;
  logic [31:0] o_data;
  logic [0:0]  arid, rid;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, rresp;
  logic        arlock, arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  arcache, arqos;

  dma_read #(
    .C_M_AXI_ID_WIDTH(1), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
    .OUT_BITS_TRANS(13), .FIFO_DEPTH(FD)
  ) dut (
    .ACLK(aclk), .ARESET(areset), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_byte_len(i_byte_len), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready), .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents seen by the slave: a fixed scramble of the byte address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'hC0FFEE00;
  endfunction

  typedef struct {logic [31:0] addr; logic [7:0] alen; bit err;} burst_t;
  typedef struct {logic [31:0] addr; int len;} sburst_t;

  burst_t      exp_b[$];
  logic [31:0] exp_w[$];
  logic [31:0] job_base = 0;
  int          err_word = -1, rlast_word = -1;
  int          act_len = 0, act_cnt = 0;
  bit          act_err = 0, err_due = 0;
  int          job_done, job_ar, job_words, job_push, job_err;
  int          done_cyc, err_cyc, start_cyc;
  bit          saw_arvalid;
  logic [31:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];
  bit          full_speed = 0, hold_ready = 0;

  // AXI read slave: random ARREADY/RVALID, data from memw, optional RRESP/RLAST faults.
  initial begin
    sburst_t     s_q[$];
    int          s_beat = 0;
    bit          a_f, r_f;
    logic [31:0] a_addr;
    logic [7:0]  a_len;
    int          w;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    forever begin
      @(negedge aclk);
      a_f = arvalid && arready; r_f = rvalid && rready; a_addr = araddr; a_len = arlen;
      @(posedge aclk); #1;
      if (areset) begin
        s_q.delete(); s_beat = 0; rvalid = 0; arready = 0; rlast = 0;
      end else begin
        if (a_f) s_q.push_back('{a_addr, int'(a_len) + 1});
        if (r_f && s_q.size() > 0) begin
          s_beat++;
          if (s_beat == s_q[0].len) begin s_q.pop_front(); s_beat = 0; end
        end
        arready = full_speed ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (s_q.size() > 0) begin
          if (!(rvalid && !r_f)) rvalid = full_speed ? 1'b1 : ($urandom_range(0, 3) != 0);
          w     = int'((s_q[0].addr - job_base) >> 2) + s_beat;
          rdata = memw(s_q[0].addr + 32'(4 * s_beat));
          rresp = (w == err_word) ? 2'b10 : 2'b00;
          rlast = (s_beat == s_q[0].len - 1) ^ (w == rlast_word);
        end else begin
          rvalid = 0; rlast = 0; rresp = 0;
        end
      end
    end
  end

  // Stream consumer.
  initial begin
    i_ready = 0;
    forever begin
      @(posedge aclk); #1;
      i_ready = hold_ready ? 1'b0 : (full_speed ? 1'b1 : ($urandom_range(0, 3) != 0));
    end
  end

  // Compare process: every cycle, DUT outputs against the job model.
  initial begin
    forever begin
      @(negedge aclk);
      if (!areset) begin
        chk("o_error", o_error, err_due);
`ifdef DMA_READ_ERR_ABORT_EN
        if (err_due) begin
          chk("abort_done", o_done, 1);
          chk("abort_valid", o_valid, 0);
          exp_w.delete(); exp_b.delete();
        end
`endif
        err_due = 0;
        if (o_error) begin job_err++; err_cyc = cyc; end
        if (o_done) begin
          job_done++; done_cyc = cyc;
          chk("done_words_left", exp_w.size(), 0);
          chk("done_bursts_left", exp_b.size(), 0);
        end
        if (arvalid) saw_arvalid = 1;
        if (arvalid && arready) begin
          job_ar++; ar_addr_log.push_back(araddr); ar_len_log.push_back(arlen);
          if (exp_b.size() == 0) chk("ar_extra", 1, 0);
          else begin
            chk("araddr", araddr, exp_b[0].addr);
            chk("arlen", arlen, exp_b[0].alen);
            chk("arsize", arsize, 3'b010);
            chk("arburst", arburst, 2'b01);
            act_len = int'(exp_b[0].alen) + 1; act_err = exp_b[0].err; act_cnt = 0;
            void'(exp_b.pop_front());
          end
        end
        if (rvalid && rready) begin
          job_push++; act_cnt++;
          if (act_cnt == act_len) begin err_due = act_err; act_cnt = 0; end
        end
        if (o_valid && i_ready) begin
          job_words++;
          if (exp_w.size() == 0) chk("stream_extra", 1, 0);
          else chk("o_data", o_data, exp_w.pop_front());
        end
      end
    end
  end

  task automatic prep_job(input logic [31:0] base, input logic [31:0] bytes,
                          input int ew, input int lw);
    int nw, off, bl;
    bit e;
    job_base = base; err_word = ew; rlast_word = lw;
    nw = int'(bytes[14:2]);
    exp_w.delete(); exp_b.delete();
    for (int i = 0; i < nw; i++) exp_w.push_back(memw(base + 32'(4 * i)));
    off = 0;
    while (off < nw) begin
      bl = (nw - off > 256) ? 256 : nw - off;
      e  = (ew >= off && ew < off + bl) || (lw >= off && lw < off + bl);
      exp_b.push_back('{base + 32'(4 * off), 8'(bl - 1), e});
      off += bl;
    end
    job_done = 0; job_ar = 0; job_words = 0; job_push = 0; job_err = 0;
    saw_arvalid = 0; ar_addr_log.delete(); ar_len_log.delete();
  endtask

  task automatic kick(input logic [31:0] base, input logic [31:0] bytes);
    @(posedge aclk); #1;
    i_start = 1; i_base_addr = base; i_byte_len = bytes;
    @(posedge aclk); #1;
    start_cyc = cyc;
    i_start = 0; i_base_addr = $urandom; i_byte_len = $urandom;
    chk("busy_after_start", o_busy, 1);
  endtask

  task automatic run_job(input logic [31:0] base, input logic [31:0] bytes,
                         input int ew, input int lw, input bit poke, input int hold);
    prep_job(base, bytes, ew, lw);
    kick(base, bytes);
    if (poke) begin
      repeat (1) @(posedge aclk);
      #1; i_start = 1; i_base_addr = 32'h0000_F000; i_byte_len = 32'h40;
      @(posedge aclk); #1; i_start = 0;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge aclk);
      #1;
      chk("bp_pushes", job_push, 8);
      chk("bp_rready", rready, 0);
      chk("bp_valid", o_valid, 1);
      hold_ready = 0;
    end
    for (int k = 0; k < 30000 && job_done == 0; k++) @(posedge aclk);
    repeat (4) @(posedge aclk);
    #1;
    chk("done_once", job_done, 1);
    chk("words_left", exp_w.size(), 0);
    chk("idle_after", o_busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int          nw, ew, lw;
    logic [31:0] base, bytes;
    areset = 1; i_start = 0; i_base_addr = 0; i_byte_len = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy", o_busy, 0);   chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0); chk("rst_valid", o_valid, 0);
    chk("rst_arvalid", arvalid, 0); chk("rst_rready", rready, 0);
    chk("rst_araddr", araddr, 0); chk("rst_arlen", arlen, 0);
    chk("fix_arid", arid, 0); chk("fix_arlock", arlock, 0); chk("fix_arcache", arcache, 0);
    chk("fix_arprot", arprot, 0); chk("fix_arqos", arqos, 4'hF);
    areset = 0;

    // Single short burst, everything ready.
    full_speed = 1;
    run_job(32'h1000, 32'd16, -1, -1, 0, 0);
    chk("t1_ar_cnt", job_ar, 1);
    chk("t1_araddr", ar_addr_log.size() > 0 ? ar_addr_log[0] : 32'hX, 32'h1000);
    chk("t1_arlen", ar_len_log.size() > 0 ? ar_len_log[0] : 8'hX, 8'd3);
    chk("t1_words", job_words, 4);

    // 320 words: full burst then a 64-beat burst.
    run_job(32'h1000, 32'h500, -1, -1, 0, 0);
    chk("t2_ar_cnt", job_ar, 2);
    chk("t2_ar1_addr", ar_addr_log.size() > 1 ? ar_addr_log[1] : 32'hX, 32'h1400);
    chk("t2_ar1_len", ar_len_log.size() > 1 ? ar_len_log[1] : 8'hX, 8'd63);
    chk("t2_words", job_words, 320);

    // Consumer stalled for 50 cycles: FIFO fills to 8 and RREADY drops.
    hold_ready = 1;
    run_job(32'h2000, 32'd64, -1, -1, 0, 50);
    chk("t3_words", job_words, 16);

    // SLVERR on beat 2 of an 8-beat burst.
    run_job(32'h3000, 32'd32, 2, -1, 0, 0);
    chk("t4_err_pulses", job_err, 1);
    chk("t4_err_cycle", err_cyc - start_cyc, 10);
`ifdef DMA_READ_ERR_ABORT_EN
    chk("t4_done_with_err", done_cyc, err_cyc);
`else
    chk("t4_words", job_words, 8);
`endif

    // Zero length (low byte bits ignored).
    run_job(32'h4000, 32'd3, -1, -1, 0, 0);
    chk("t5_done_latency", done_cyc - start_cyc, 2);
    chk("t5_no_ar", saw_arvalid, 0);

    // Reset in the middle of a data phase.
    full_speed = 0;
    prep_job(32'h8000, 32'h800, -1, -1);
    kick(32'h8000, 32'h800);
    for (int k = 0; k < 3000 && job_push < 20; k++) @(posedge aclk);
    chk("t6_reached_data", job_push >= 20, 1);
    #2; areset = 1; #1;
    chk("t6_busy", o_busy, 0);   chk("t6_valid", o_valid, 0);
    chk("t6_done", o_done, 0);   chk("t6_error", o_error, 0);
    chk("t6_arvalid", arvalid, 0); chk("t6_rready", rready, 0);
    chk("t6_araddr", araddr, 0); chk("t6_arlen", arlen, 0);
    exp_w.delete(); exp_b.delete(); act_cnt = 0; act_len = 0; err_due = 0; job_done = 0;
    repeat (3) @(posedge aclk);
    #2; areset = 0;
    repeat (5) @(posedge aclk);
    chk("t6_no_done", job_done, 0);
    run_job(32'h9000, 32'd16, -1, -1, 0, 0);
    chk("t6_words", job_words, 4);

    // Randomized jobs with occasional faults and ignored mid-job starts.
    for (int r = 0; r < 6; r++) begin
      base  = $urandom & 32'h000F_FC00;
      bytes = 32'($urandom_range(0, 32'h600));
      nw    = int'(bytes[14:2]);
      ew    = (nw > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, nw - 1)) : -1;
      lw    = (nw > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, nw - 1)) : -1;
      run_job(base, bytes, ew, lw, (r % 2 == 1) && nw > 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
